// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: drives one external 32-bit CLA a word per clock, LSW first,
// to add or subtract WORDS x 32-bit operands, with the carry registered between words.
// Optional signed-overflow flag enabled by defining CLA_SEQ_OVERFLOW_EN; without it
// res_ovf is tied to 0 and the port list is unchanged.
module cla_multiword_seq #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned IDXW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [32*WORDS-1:0]   cmd_a,
  input  logic [32*WORDS-1:0]   cmd_b,
  input  logic                  cmd_cin,
  input  logic                  cmd_sub,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_s,
  input  logic                  add_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [32*WORDS-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic                  busy
);

  localparam int unsigned W = 32 * WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry;
  logic [IDXW-1:0] idx;
  logic            last_word;

  assign last_word = (idx == IDXW'(WORDS - 1));

  // Select the current word for the shared adder; inputs are held at 0 outside RUN.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_cin = carry;
      for (int unsigned w = 0; w < WORDS; w++) begin
        if (idx == IDXW'(w)) begin
          add_a = a_reg[32*w +: 32];
          add_b = b_reg[32*w +: 32];
        end
      end
    end
  end

  // Control FSM plus operand, carry, index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            a_reg     <= cmd_a;
            b_reg     <= cmd_sub ? ~cmd_b : cmd_b;
            carry     <= cmd_sub ? 1'b1 : cmd_cin;
            idx       <= '0;
            res_sum   <= '0;
            state     <= RUN;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx == IDXW'(w)) res_sum[32*w +: 32] <= add_s;
          end
          carry <= add_cout;
          idx   <= idx + IDXW'(1);
          if (last_word) begin
            res_cout  <= add_cout;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CLA_SEQ_OVERFLOW_EN
  logic ovf_q;

  // Signed overflow from the top word's sign bits, captured on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last_word) begin
      ovf_q <= (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
    end
  end

  assign res_ovf = ovf_q;
`else
  assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_multiword_seq.sv
// tb_cla_multiword_seq: randomized and directed checks of cla_multiword_seq against
// a whole-operand arithmetic reference; the external CLA is a behavioural adder here.
module tb_cla_multiword_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned IDXW  = 4;
  localparam int unsigned W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_cin;
  logic         cmd_sub;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic         add_cin;
  logic [31:0]  add_s;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] got_sum;
  logic         got_cout;
  logic         got_ovf;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 32-bit CLA.
  assign {add_cout, add_s} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  cla_multiword_seq #(.WORDS(WORDS), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cin   (cmd_cin),
    .cmd_sub   (cmd_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WORDS); i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One full operation from command to consumed result; called at a negedge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int hold, input bit chain,
                       output logic [W-1:0] o_sum, output logic o_cout, output logic o_ovf);
    logic [W-1:0] eb;
    logic [W:0]   full;
    logic         eovf;
    int           n;
    int           lat;
    eb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, eb} + (W+1)'(sub | cin);
`ifdef CLA_SEQ_OVERFLOW_EN
    eovf = (a[W-1] == eb[W-1]) && (full[W-1] != a[W-1]);
`else
    eovf = 1'b0;
`endif
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
    cmd_sub   = sub;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < int'(2*WORDS + 8)) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", W'(cmd_ready), W'(1));
    @(negedge clk);
    if (chain) begin
      cmd_a   = rand_word();
      cmd_b   = rand_word();
      cmd_sub = 1'($urandom);
      cmd_cin = 1'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    check("run_busy", W'(busy), W'(1));
    check("run_cmd_ready", W'(cmd_ready), W'(0));
    lat = 1;
    while (!res_valid && lat < int'(4*WORDS)) begin
      @(negedge clk);
      lat++;
    end
    check("latency", W'(lat), W'(WORDS + 1));
    check("res_sum", res_sum, full[W-1:0]);
    check("res_cout", W'(res_cout), W'(full[W]));
    check("res_ovf", W'(res_ovf), W'(eovf));
    check("done_busy", W'(busy), W'(1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", W'(res_valid), W'(1));
      check("hold_sum", res_sum, full[W-1:0]);
      check("hold_cmd_ready", W'(cmd_ready), W'(0));
      check("hold_add_a", W'(add_a), W'(0));
    end
    o_sum  = res_sum;
    o_cout = res_cout;
    o_ovf  = res_ovf;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("consume_valid", W'(res_valid), W'(0));
    check("consume_cmd_ready", W'(cmd_ready), W'(1));
    check("consume_busy", W'(busy), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_cin   = 1'b0;
    cmd_sub   = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", W'(cmd_ready), W'(1));
    check("rst_res_valid", W'(res_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_res_sum", res_sum, '0);
    check("rst_res_cout", W'(res_cout), W'(0));
    check("rst_res_ovf", W'(res_ovf), W'(0));
    check("idle_add_a", W'(add_a), W'(0));

    // Carry ripples across three word boundaries.
    a = {32'h0, {96{1'b1}}};
    do_op(a, W'(1), 1'b0, 1'b0, 0, 1'b0, got_sum, got_cout, got_ovf);
    check("ripple_sum_lit", got_sum, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
    check("ripple_cout_lit", W'(got_cout), W'(0));

    // Full wrap through the carry-in.
    do_op({W{1'b1}}, '0, 1'b1, 1'b0, 0, 1'b0, got_sum, got_cout, got_ovf);
    check("wrap_sum_lit", got_sum, '0);
    check("wrap_cout_lit", W'(got_cout), W'(1));
    check("wrap_ovf_lit", W'(got_ovf), W'(0));

    // Subtract with and without borrow.
    do_op(W'(5), W'(7), 1'b0, 1'b1, 0, 1'b0, got_sum, got_cout, got_ovf);
    check("sub_borrow_lit", got_sum, {{(W-4){1'b1}}, 4'hE});
    check("sub_borrow_cout_lit", W'(got_cout), W'(0));
    do_op(W'(7), W'(5), 1'b1, 1'b1, 0, 1'b0, got_sum, got_cout, got_ovf);
    check("sub_noborrow_lit", got_sum, W'(2));
    check("sub_noborrow_cout_lit", W'(got_cout), W'(1));

    // Positive overflow into the sign bit.
    do_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, 0, 1'b0, got_sum, got_cout, got_ovf);
    check("ovf_sum_lit", got_sum, {1'b1, {(W-1){1'b0}}});
`ifdef CLA_SEQ_OVERFLOW_EN
    check("ovf_flag_lit", W'(got_ovf), W'(1));
`else
    check("ovf_flag_lit", W'(got_ovf), W'(0));
`endif

    // Backpressure for 10 cycles, with a new command held through RUN and DONE.
    do_op(rand_word(), rand_word(), 1'b0, 1'b0, 10, 1'b1, got_sum, got_cout, got_ovf);
    check("b2b_ready", W'(cmd_ready), W'(1));
    do_op(rand_word(), rand_word(), 1'b1, 1'b0, 2, 1'b0, got_sum, got_cout, got_ovf);

    // Reset while the index is at word 2.
    cmd_a = W'(32'h1234_5678); cmd_b = {W{1'b1}}; cmd_cin = 1'b0; cmd_sub = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cmd_ready", W'(cmd_ready), W'(1));
    check("midrst_res_valid", W'(res_valid), W'(0));
    check("midrst_res_sum", res_sum, '0);
    check("midrst_busy", W'(busy), W'(0));
    for (int i = 0; i < int'(WORDS + 2); i++) begin
      @(negedge clk);
      check("midrst_no_result", W'(res_valid), W'(0));
    end
    do_op(W'(3), W'(4), 1'b0, 1'b0, 0, 1'b0, got_sum, got_cout, got_ovf);
    check("after_rst_sum_lit", got_sum, W'(7));

    // Randomized operations with corner-biased operands.
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 4));
      a = rand_word();
      b = rand_word();
      if (sel == 1) a = {W{1'b1}};
      if (sel == 2) b = '0;
      if (sel == 3) a[W-1] = ~b[W-1];
      if (sel == 4) a = {1'b0, {(W-1){1'b1}}};
      do_op(a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), got_sum, got_cout, got_ovf);
    end
    cmd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
